mod_addsub_pipe: RTL

//   Pipelined, multi-lane modular adder/subtractor for Kyber-class NTT datapaths.

---
 rtl/kyber_pkg.sv | 13 +
 rtl/mod_addsub_lane.sv | 44 ++++
 rtl/mod_addsub_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared constants and operation encoding for the Kyber coefficient datapath.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_W = 12;

    // Per-beat operation select carried on in_sub.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/mod_addsub_lane.sv
// Single-lane combinational modular add/sub front end.
// Produces the raw sum/difference, the Q-corrected candidate, and a select bit
// that is 1 when the candidate (not the raw value) is the reduced result.
// All arithmetic is W+1 bits wide so the sign of the intermediate is visible.
module mod_addsub_lane
    import kyber_pkg::*;
#(
    parameter int W = KYBER_W,
    parameter int Q = KYBER_Q
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] raw_o,
    output logic [W-1:0] cand_o,
    output logic         sel_o
);

    localparam logic [W:0] QX = (W+1)'(Q);

    logic [W:0] raw_x;
    logic [W:0] cand_x;

    // Add: candidate is s-Q, chosen unless negative.
    // Sub: candidate is d+Q, chosen only when d is negative.
    always_comb begin
        raw_x  = '0;
        cand_x = '0;
        sel_o  = 1'b0;
        if (op_e'(sub_i) == OP_SUB) begin
            raw_x  = {1'b0, a_i} - {1'b0, b_i};
            cand_x = raw_x + QX;
            sel_o  = raw_x[W];
        end else begin
            raw_x  = {1'b0, a_i} + {1'b0, b_i};
            cand_x = raw_x - QX;
            sel_o  = ~cand_x[W];
        end
    end

    assign raw_o  = raw_x[W-1:0];
    assign cand_o = cand_x[W-1:0];

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined multi-lane modular adder/subtractor.
// Handshake: a beat transfers on a side when valid && ready are both high at a
// rising clk edge; a producer holds valid and data stable until that happens.
// in_ready depends only on pipeline occupancy and out_ready, never on in_valid.
// S1 holds the raw value, the corrected candidate and the select bit (which
// encodes the beat's add/sub op together with the sign); S2 holds the result.
module mod_addsub_pipe
    import kyber_pkg::*;
#(
    parameter int W     = KYBER_W,
    parameter int Q     = KYBER_Q,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sub,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic [31:0]          beat_cnt
);

    logic [LANES*W-1:0] lane_raw;
    logic [LANES*W-1:0] lane_cand;
    logic [LANES-1:0]   lane_sel;

    logic               s1_valid_q, s1_valid_d;
    logic [LANES*W-1:0] s1_raw_q,   s1_raw_d;
    logic [LANES*W-1:0] s1_cand_q,  s1_cand_d;
    logic [LANES-1:0]   s1_sel_q,   s1_sel_d;
    logic               s2_valid_q, s2_valid_d;
    logic [LANES*W-1:0] s2_data_q,  s2_data_d;
    logic [31:0]        cnt_q,      cnt_d;

    logic               s1_adv;
    logic               s2_adv;
    logic [LANES*W-1:0] sel_data;

    // One independent combinational lane per coefficient.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mod_addsub_lane #(
            .W (W),
            .Q (Q)
        ) u_lane (
            .a_i    (in_a[g*W +: W]),
            .b_i    (in_b[g*W +: W]),
            .sub_i  (in_sub),
            .raw_o  (lane_raw[g*W +: W]),
            .cand_o (lane_cand[g*W +: W]),
            .sel_o  (lane_sel[g])
        );
    end

    // Stage advance conditions: a stage may load when empty or when draining.
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    // Final per-lane reduction mux feeding S2.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < LANES; i++) begin
            sel_data[i*W +: W] = s1_sel_q[i] ? s1_cand_q[i*W +: W] : s1_raw_q[i*W +: W];
        end
    end

    // Next-state for both pipeline stages and the saturating delivery counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
        s1_cand_d  = s1_cand_q;
        s1_sel_d   = s1_sel_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        cnt_d      = cnt_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_raw_d  = lane_raw;
                s1_cand_d = lane_cand;
                s1_sel_d  = lane_sel;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = sel_data;
            end
        end

        if (s2_valid_q && out_ready && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Pipeline and counter registers; reset drops any in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_cand_q  <= '0;
            s1_sel_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_raw_q   <= s1_raw_d;
            s1_cand_q  <= s1_cand_d;
            s1_sel_q   <= s1_sel_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign beat_cnt  = cnt_q;

endmodule
